// File: rtl/grid_paint_ctrl_if.sv
// -----------------------------------------------------------------------------
// grid_paint_ctrl_if
//   Signal bundle between grid_paint_ctrl and its neighbours. It carries the
//   keypad key strobe and handshake, the VGA synchronous read port, and the
//   status outputs that drive the 7-seg display.
//   master : keypad scanner / VGA renderer side (drives keys and rd_addr)
//   slave  : grid_paint_ctrl side
// -----------------------------------------------------------------------------
interface grid_paint_ctrl_if #(
  parameter int ADDR_W     = 4,
  parameter int COLOR_BITS = 3
);
  logic                  key_valid;
  logic [3:0]            key_code;
  logic                  key_ready;
  logic [ADDR_W-1:0]     rd_addr;
  logic [COLOR_BITS-1:0] rd_data;
  logic [ADDR_W-1:0]     cursor_addr;
  logic [COLOR_BITS-1:0] cur_color;
  logic                  busy;
  logic                  wr_event;

  modport master (
    output key_valid, key_code, rd_addr,
    input  key_ready, rd_data, cursor_addr, cur_color, busy, wr_event
  );

  modport slave (
    input  key_valid, key_code, rd_addr,
    output key_ready, rd_data, cursor_addr, cur_color, busy, wr_event
  );
endinterface

// File: rtl/grid_paint_ctrl.sv
// -----------------------------------------------------------------------------
// grid_paint_ctrl
//   This is a keypad-driven editor for a GRID_W x GRID_H array of colour cells.
//   - After reset, the controller clears every cell to 0. Keys are taken only
//     in IDLE.
//   - Keys move the cursor. The cursor wraps on each axis and does not carry
//     between axes.
//   - Keys step the current colour, which wraps modulo 2^COLOR_BITS.
//   - Keys paint or erase the cell under the cursor.
//   - The VGA side reads cells through an independent read-first port with
//     one cycle of latency.
//   Optional feature macro: GRID_FILL_EN. When it is defined, key 0xF fills
//   every cell with the current colour.
// -----------------------------------------------------------------------------
module grid_paint_ctrl #(
  parameter int GRID_W     = 4,
  parameter int GRID_H     = 4,
  parameter int COLOR_BITS = 3
) (
  input logic               clk,
  input logic               rst,
  grid_paint_ctrl_if.slave  bus
);
  localparam int N_CELLS = GRID_W * GRID_H;
  localparam int ADDR_W  = $clog2(N_CELLS);
  localparam int X_W     = $clog2(GRID_W);
  localparam int Y_W     = $clog2(GRID_H);

  localparam logic [ADDR_W-1:0]     LAST_CELL = ADDR_W'(N_CELLS - 1);
  localparam logic [X_W-1:0]        X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]        Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [COLOR_BITS-1:0] COLOR_RST = COLOR_BITS'(1);

  localparam logic [3:0] KEY_UP     = 4'h2;
  localparam logic [3:0] KEY_DOWN   = 4'h8;
  localparam logic [3:0] KEY_LEFT   = 4'h4;
  localparam logic [3:0] KEY_RIGHT  = 4'h6;
  localparam logic [3:0] KEY_PAINT  = 4'h5;
  localparam logic [3:0] KEY_ERASE  = 4'hC;
  localparam logic [3:0] KEY_COL_DN = 4'hA;
  localparam logic [3:0] KEY_COL_UP = 4'hB;
`ifdef GRID_FILL_EN
  localparam logic [3:0] KEY_FILL   = 4'hF;
`endif

  typedef enum logic [1:0] {
    S_CLEAR,
`ifdef GRID_FILL_EN
    S_FILL,
`endif
    S_IDLE
  } state_t;

  state_t                r_state, w_next_state;
  logic [ADDR_W-1:0]     r_ptr, w_ptr_next;       // shared CLEAR/FILL sweep pointer
  logic [X_W-1:0]        r_x, w_x_next;
  logic [Y_W-1:0]        r_y, w_y_next;
  logic [COLOR_BITS-1:0] r_color, w_color_next;
  logic                  r_wr_event, w_wr_event_next;
  logic [COLOR_BITS-1:0] r_rd_data;
  logic [COLOR_BITS-1:0] r_mem [N_CELLS];

  logic                  w_we;
  logic [ADDR_W-1:0]     w_waddr;
  logic [COLOR_BITS-1:0] w_wdata;
  logic [ADDR_W-1:0]     w_cursor_addr;

  // The cursor cell is stored in row-major order.
  assign w_cursor_addr = ADDR_W'(r_y) * ADDR_W'(GRID_W) + ADDR_W'(r_x);

  // State register. Reset always restarts a full CLEAR, even mid-sequence.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_next_state;
  end

  // Next-state logic, key decode and the single memory write port.
  // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_next_state    = r_state;
    w_ptr_next      = r_ptr;
    w_x_next        = r_x;
    w_y_next        = r_y;
    w_color_next    = r_color;
    w_wr_event_next = 1'b0;
    w_we            = 1'b0;
    w_waddr         = r_ptr;
    w_wdata         = '0;

    case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        if (r_ptr == LAST_CELL) begin
          w_ptr_next   = '0;
          w_next_state = S_IDLE;
        end else begin
          w_ptr_next = r_ptr + ADDR_W'(1);
        end
      end

      S_IDLE: begin
        if (bus.key_valid) begin
          case (bus.key_code)
            KEY_UP:     w_y_next = (r_y == '0)    ? Y_MAX : r_y - Y_W'(1);
            KEY_DOWN:   w_y_next = (r_y == Y_MAX) ? '0    : r_y + Y_W'(1);
            KEY_LEFT:   w_x_next = (r_x == '0)    ? X_MAX : r_x - X_W'(1);
            KEY_RIGHT:  w_x_next = (r_x == X_MAX) ? '0    : r_x + X_W'(1);
            KEY_COL_DN: w_color_next = r_color - COLOR_BITS'(1);
            KEY_COL_UP: w_color_next = r_color + COLOR_BITS'(1);
            KEY_PAINT: begin
              w_we            = 1'b1;
              w_waddr         = w_cursor_addr;
              w_wdata         = r_color;
              w_wr_event_next = 1'b1;
            end
            KEY_ERASE: begin
              w_we            = 1'b1;
              w_waddr         = w_cursor_addr;
              w_wr_event_next = 1'b1;
            end
`ifdef GRID_FILL_EN
            KEY_FILL: begin
              w_ptr_next   = '0;
              w_next_state = S_FILL;
            end
`endif
            default: ;
          endcase
        end
      end

`ifdef GRID_FILL_EN
      // Keys are dropped during FILL, so r_color holds the colour that was
      // current when 0xF was accepted.
      S_FILL: begin
        w_we    = 1'b1;
        w_wdata = r_color;
        if (r_ptr == LAST_CELL) begin
          w_ptr_next      = '0;
          w_next_state    = S_IDLE;
          w_wr_event_next = 1'b1;
        end else begin
          w_ptr_next = r_ptr + ADDR_W'(1);
        end
      end
`endif

      default: w_next_state = S_CLEAR;
    endcase
  end

  // Datapath registers: sweep pointer, cursor, colour and edit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_color    <= COLOR_RST;
      r_wr_event <= 1'b0;
    end else begin
      r_ptr      <= w_ptr_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_color    <= w_color_next;
      r_wr_event <= w_wr_event_next;
    end
  end

  // Cell storage write port.
  // NOTE: the array has no reset; the CLEAR sweep zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // VGA read port. It is read-first, so a write in the same cycle shows up on
  // the next read. Out-of-range addresses read as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_rd_data <= '0;
    else if (32'(bus.rd_addr) < N_CELLS)    r_rd_data <= r_mem[bus.rd_addr];
    else                                    r_rd_data <= '0;
  end

  assign bus.key_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.cursor_addr = w_cursor_addr;
  assign bus.cur_color   = r_color;
  assign bus.wr_event    = r_wr_event;
  assign bus.rd_data     = r_rd_data;
endmodule

// File: tb/tb_grid_paint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grid_paint_ctrl
//   Self-checking bench for grid_paint_ctrl with a 4x4 grid and 3-bit colour.
//   A simple array model holds the expected cursor, colour and cell values.
//   Also covers the GRID_FILL_EN build when that macro is defined.
// -----------------------------------------------------------------------------
module tb_grid_paint_ctrl;
  localparam int GW = 4;
  localparam int GH = 4;
  localparam int CB = 3;
  localparam int N  = GW * GH;
  localparam int AW = 4;
  localparam int NCOL = 1 << CB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grid_paint_ctrl_if #(.ADDR_W(AW), .COLOR_BITS(CB)) bus ();

  grid_paint_ctrl #(.GRID_W(GW), .GRID_H(GH), .COLOR_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  int m_x, m_y, m_color;
  int m_mem [N];

  typedef struct {
    logic [3:0] key;
    int         exp_addr;
    int         exp_color;
    bit         exp_wr;
  } vec_t;
  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_addr();
    return m_y * GW + m_x;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_color = 1;
    for (int i = 0; i < N; i++) m_mem[i] = 0;
  endtask

  // Effect of one accepted key in IDLE (0xF is handled separately).
  task automatic model_key(input logic [3:0] code, output bit wr);
    wr = 1'b0;
    case (code)
      4'h2: m_y = (m_y + GH - 1) % GH;
      4'h8: m_y = (m_y + 1) % GH;
      4'h4: m_x = (m_x + GW - 1) % GW;
      4'h6: m_x = (m_x + 1) % GW;
      4'hA: m_color = (m_color + NCOL - 1) % NCOL;
      4'hB: m_color = (m_color + 1) % NCOL;
      4'h5: begin m_mem[m_addr()] = m_color; wr = 1'b1; end
      4'hC: begin m_mem[m_addr()] = 0;       wr = 1'b1; end
      default: ;
    endcase
  endtask

  // Apply one key in IDLE and compare cursor, colour and edit pulse.
  task automatic do_key(input logic [3:0] code, input string tag);
    bit wr;
    model_key(code, wr);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    step();
    bus.key_valid = 1'b0;
    check({tag, ".cursor"}, bus.cursor_addr, m_addr());
    check({tag, ".color"},  bus.cur_color,   m_color);
    check({tag, ".wr"},     bus.wr_event,    int'(wr));
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < N; a++) begin
      bus.rd_addr = AW'(a);
      step();
      check($sformatf("%s.mem[%0d]", tag, a), bus.rd_data, m_mem[a]);
    end
  endtask

  // Assert reset, check the reset values, release it and time the CLEAR
  // sweep. A key strobe sent mid-sweep must be dropped.
  task automatic reset_and_count(input string tag);
    int cnt;
    rst = 1'b1;
    model_reset();
    #1;
    check({tag, ".rst_busy"},   bus.busy,        1);
    check({tag, ".rst_ready"},  bus.key_ready,   0);
    check({tag, ".rst_wr"},     bus.wr_event,    0);
    check({tag, ".rst_rd"},     bus.rd_data,     0);
    check({tag, ".rst_cursor"}, bus.cursor_addr, 0);
    check({tag, ".rst_color"},  bus.cur_color,   1);
    step();
    step();
    rst = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      bus.key_valid = (cnt == 5);
      bus.key_code  = 4'h6;
      cnt++;
      step();
    end
    bus.key_valid = 1'b0;
    check({tag, ".clear_cycles"}, 32'(cnt), N);
    check({tag, ".ready"},  bus.key_ready,   1);
    check({tag, ".wr"},     bus.wr_event,    0);
    check({tag, ".cursor"}, bus.cursor_addr, 0);
    check({tag, ".color"},  bus.cur_color,   1);
  endtask

  initial begin
    int  old_val;
    int  exp_rd;
    int  rd;
    bit  wr;
    logic [3:0] code;
    bit  valid;
`ifdef GRID_FILL_EN
    int  cnt;
    int  wr_seen;
    int  saved_addr;
`endif

    vecs[0]  = '{4'h4,  3, 1, 1'b0};
    vecs[1]  = '{4'h2, 15, 1, 1'b0};
    vecs[2]  = '{4'h6, 12, 1, 1'b0};
    vecs[3]  = '{4'h8,  0, 1, 1'b0};
    vecs[4]  = '{4'hA,  0, 0, 1'b0};
    vecs[5]  = '{4'hA,  0, 7, 1'b0};
    vecs[6]  = '{4'hB,  0, 0, 1'b0};
    vecs[7]  = '{4'hB,  0, 1, 1'b0};
    vecs[8]  = '{4'h6,  1, 1, 1'b0};
    vecs[9]  = '{4'h6,  2, 1, 1'b0};
    vecs[10] = '{4'h8,  6, 1, 1'b0};
    vecs[11] = '{4'h5,  6, 1, 1'b1};
    vecs[12] = '{4'h3,  6, 1, 1'b0};
    vecs[13] = '{4'h6,  7, 1, 1'b0};
    vecs[14] = '{4'hB,  7, 2, 1'b0};
    vecs[15] = '{4'h5,  7, 2, 1'b1};
    vecs[16] = '{4'hC,  7, 2, 1'b1};
    vecs[17] = '{4'h0,  7, 2, 1'b0};

    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.rd_addr   = '0;

    // Power-up clear
    reset_and_count("por");
    check_mem("por");

    // Table-driven key vectors; the model tracks memory alongside
    for (int i = 0; i < 18; i++) begin
      model_key(vecs[i].key, wr);
      bus.key_valid = 1'b1;
      bus.key_code  = vecs[i].key;
      step();
      bus.key_valid = 1'b0;
      check($sformatf("vec%0d.cursor", i), bus.cursor_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d.color", i),  bus.cur_color,   vecs[i].exp_color);
      check($sformatf("vec%0d.wr", i),     bus.wr_event,    int'(vecs[i].exp_wr));
      step();
      check($sformatf("vec%0d.wr_off", i), bus.wr_event,    0);
    end
    check_mem("table");

    // Read-during-write on the same cell: old value first, new value next
    do_key(4'h4, "rdw_mv0");
    do_key(4'h4, "rdw_mv1");
    check("rdw.cursor", bus.cursor_addr, 5);
    old_val       = m_mem[5];
    model_key(4'h5, wr);
    bus.rd_addr   = AW'(5);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    step();
    bus.key_valid = 1'b0;
    check("rdw.old", bus.rd_data, old_val);
    step();
    check("rdw.new", bus.rd_data, m_mem[5]);

    // Randomised keys and read addresses against the model
    for (int it = 0; it < 300; it++) begin
      code  = 4'($urandom_range(0, 15));
      valid = ($urandom_range(0, 3) != 0);
`ifdef GRID_FILL_EN
      if (code == 4'hF) code = 4'h0;
`endif
      rd     = $urandom_range(0, N - 1);
      exp_rd = m_mem[rd];
      wr     = 1'b0;
      if (valid) model_key(code, wr);
      bus.key_valid = valid;
      bus.key_code  = code;
      bus.rd_addr   = AW'(rd);
      step();
      bus.key_valid = 1'b0;
      check($sformatf("rnd%0d.rd", it),     bus.rd_data,     exp_rd);
      check($sformatf("rnd%0d.cursor", it), bus.cursor_addr, m_addr());
      check($sformatf("rnd%0d.color", it),  bus.cur_color,   m_color);
      check($sformatf("rnd%0d.wr", it),     bus.wr_event,    int'(wr));
    end
    check_mem("random");

`ifdef GRID_FILL_EN
    // FILL with colour 4. A strobe mid-fill must be dropped.
    for (int k = 0; k < NCOL && m_color != 4; k++) do_key(4'hB, "fill_col");
    check("fill.color_set", bus.cur_color, 4);
    saved_addr    = m_addr();
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hF;
    step();
    cnt     = 0;
    wr_seen = 0;
    while (bus.busy && cnt < 40) begin
      bus.key_valid = (cnt == 4);
      bus.key_code  = 4'h6;
      if (bus.wr_event) wr_seen++;
      cnt++;
      step();
    end
    bus.key_valid = 1'b0;
    for (int i = 0; i < N; i++) m_mem[i] = m_color;
    check("fill.cycles",  32'(cnt), N);
    check("fill.no_early_wr", 32'(wr_seen), 0);
    check("fill.wr",      bus.wr_event, 1);
    step();
    check("fill.wr_off",  bus.wr_event,    0);
    check("fill.cursor",  bus.cursor_addr, saved_addr);
    check("fill.color",   bus.cur_color,   4);
    check_mem("fill");

    // Reset at fill cycle 7 aborts it and re-clears everything
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hF;
    step();
    bus.key_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("fill_abort.busy", bus.busy, 1);
    reset_and_count("fill_abort");
    check_mem("fill_abort");
`else
    // 0xF is an unmapped key in this build
    do_key(4'hF, "nofill");
    check("nofill.busy", bus.busy, 0);
    check_mem("nofill");
`endif

    // Reset in the middle of CLEAR restarts the full sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) step();
    check("mid_clear.busy", bus.busy, 1);
    reset_and_count("mid_clear");
    check_mem("mid_clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
